// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the main-memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_I_RD = 3'd1,
    ST_D_RD = 3'd2,
    ST_D_WR = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam int BLK_OFFSET_BITS = 5;
  localparam int BLK_OFFSET_MASK = (1 << BLK_OFFSET_BITS) - 1;

  // One-hot grant bit positions.
  localparam int GNT_IC  = 0;
  localparam int GNT_DRD = 1;
  localparam int GNT_DWR = 2;

endpackage

// File: rtl/mem_port_prio_sel.sv
// Combinational requester selection: fixed priority (DC write > DC read > IC)
// with IC forced to win once the starvation count reaches its limit.
module mem_port_prio_sel
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             ic_req,
  input  logic             dc_rd_req,
  input  logic             dc_wr_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic [2:0]       grant
);

  always_comb begin
    grant = '0;
    if (ic_req && (starve_cnt == CNT_W'(STARVE_LIMIT))) begin
      grant[GNT_IC] = 1'b1;
    end else if (dc_wr_req) begin
      grant[GNT_DWR] = 1'b1;
    end else if (dc_rd_req) begin
      grant[GNT_DRD] = 1'b1;
    end else if (ic_req) begin
      grant[GNT_IC] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises I-cache refills and D-cache refills/writebacks onto one block
// memory port, one transaction at a time; all outputs are registered.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int BLK_W        = 256,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [BLK_W-1:0]  ic_data,
  output logic              ic_done,
  input  logic              dc_rd_req,
  input  logic [ADDR_W-1:0] dc_rd_addr,
  output logic [BLK_W-1:0]  dc_rd_data,
  output logic              dc_rd_done,
  input  logic              dc_wr_req,
  input  logic [ADDR_W-1:0] dc_wr_addr,
  input  logic [BLK_W-1:0]  dc_wr_data,
  output logic              dc_wr_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_blk_read,
  output logic              mem_blk_write,
  output logic [BLK_W-1:0]  mem_wdata,
  input  logic [BLK_W-1:0]  mem_rdata,
  input  logic              mem_rd_valid,
  input  logic              mem_wr_valid,
  output logic              busy
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BLK_OFFSET_MASK);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_cmd_q, rd_cmd_d;
  logic              wr_cmd_q, wr_cmd_d;
  logic [BLK_W-1:0]  wdata_q, wdata_d;
  logic [BLK_W-1:0]  ic_data_q, ic_data_d;
  logic [BLK_W-1:0]  dc_rd_data_q, dc_rd_data_d;
  logic              ic_done_q, ic_done_d;
  logic              dc_rd_done_q, dc_rd_done_d;
  logic              dc_wr_done_q, dc_wr_done_d;
  logic              busy_q, busy_d;
  logic [2:0]        grant;

  mem_port_prio_sel #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_prio_sel (
    .ic_req     (ic_req),
    .dc_rd_req  (dc_rd_req),
    .dc_wr_req  (dc_wr_req),
    .starve_cnt (starve_q),
    .grant      (grant)
  );

  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    addr_d       = addr_q;
    rd_cmd_d     = rd_cmd_q;
    wr_cmd_d     = wr_cmd_q;
    wdata_d      = wdata_q;
    ic_data_d    = ic_data_q;
    dc_rd_data_d = dc_rd_data_q;
    ic_done_d    = 1'b0;
    dc_rd_done_d = 1'b0;
    dc_wr_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Only D-side grants made while IC is waiting count towards starvation.
        if (!ic_req || grant[GNT_IC]) begin
          starve_d = '0;
        end else if (starve_q != CNT_W'(STARVE_LIMIT)) begin
          starve_d = starve_q + 1'b1;
        end

        if (grant[GNT_DWR]) begin
          state_d  = ST_D_WR;
          addr_d   = dc_wr_addr & ALIGN_MASK;
          wdata_d  = dc_wr_data;
          wr_cmd_d = 1'b1;
        end else if (grant[GNT_DRD]) begin
          state_d  = ST_D_RD;
          addr_d   = dc_rd_addr & ALIGN_MASK;
          rd_cmd_d = 1'b1;
        end else if (grant[GNT_IC]) begin
          state_d  = ST_I_RD;
          addr_d   = ic_addr & ALIGN_MASK;
          rd_cmd_d = 1'b1;
        end
      end
      ST_I_RD: begin
        if (mem_rd_valid) begin
          state_d   = ST_DONE;
          rd_cmd_d  = 1'b0;
          ic_data_d = mem_rdata;
          ic_done_d = 1'b1;
        end
      end
      ST_D_RD: begin
        if (mem_rd_valid) begin
          state_d      = ST_DONE;
          rd_cmd_d     = 1'b0;
          dc_rd_data_d = mem_rdata;
          dc_rd_done_d = 1'b1;
        end
      end
      ST_D_WR: begin
        if (mem_wr_valid) begin
          state_d      = ST_DONE;
          wr_cmd_d     = 1'b0;
          dc_wr_done_d = 1'b1;
        end
      end
      // Dead cycle lets the finished requester drop its req before re-arbitration.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= ST_IDLE;
      starve_q     <= '0;
      addr_q       <= '0;
      rd_cmd_q     <= 1'b0;
      wr_cmd_q     <= 1'b0;
      wdata_q      <= '0;
      ic_data_q    <= '0;
      dc_rd_data_q <= '0;
      ic_done_q    <= 1'b0;
      dc_rd_done_q <= 1'b0;
      dc_wr_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      addr_q       <= addr_d;
      rd_cmd_q     <= rd_cmd_d;
      wr_cmd_q     <= wr_cmd_d;
      wdata_q      <= wdata_d;
      ic_data_q    <= ic_data_d;
      dc_rd_data_q <= dc_rd_data_d;
      ic_done_q    <= ic_done_d;
      dc_rd_done_q <= dc_rd_done_d;
      dc_wr_done_q <= dc_wr_done_d;
      busy_q       <= busy_d;
    end
  end

  assign mem_addr      = addr_q;
  assign mem_blk_read  = rd_cmd_q;
  assign mem_blk_write = wr_cmd_q;
  assign mem_wdata     = wdata_q;
  assign ic_data       = ic_data_q;
  assign dc_rd_data    = dc_rd_data_q;
  assign ic_done       = ic_done_q;
  assign dc_rd_done    = dc_rd_done_q;
  assign dc_wr_done    = dc_wr_done_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         ic_req;
  logic [31:0]  ic_addr;
  logic [255:0] ic_data;
  logic         ic_done;
  logic         dc_rd_req;
  logic [31:0]  dc_rd_addr;
  logic [255:0] dc_rd_data;
  logic         dc_rd_done;
  logic         dc_wr_req;
  logic [31:0]  dc_wr_addr;
  logic [255:0] dc_wr_data;
  logic         dc_wr_done;
  logic [31:0]  mem_addr;
  logic         mem_blk_read;
  logic         mem_blk_write;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_rd_valid;
  logic         mem_wr_valid;
  logic         busy;

  mem_port_arbiter #(
    .ADDR_W       (32),
    .BLK_W        (256),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .ic_req        (ic_req),
    .ic_addr       (ic_addr),
    .ic_data       (ic_data),
    .ic_done       (ic_done),
    .dc_rd_req     (dc_rd_req),
    .dc_rd_addr    (dc_rd_addr),
    .dc_rd_data    (dc_rd_data),
    .dc_rd_done    (dc_rd_done),
    .dc_wr_req     (dc_wr_req),
    .dc_wr_addr    (dc_wr_addr),
    .dc_wr_data    (dc_wr_data),
    .dc_wr_done    (dc_wr_done),
    .mem_addr      (mem_addr),
    .mem_blk_read  (mem_blk_read),
    .mem_blk_write (mem_blk_write),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_rd_valid  (mem_rd_valid),
    .mem_wr_valid  (mem_wr_valid),
    .busy          (busy)
  );

  always #5 CLK = ~CLK;

  int    n_chk  = 0;
  int    n_pass = 0;
  string tcase  = "reset";

  // Reference model: phase 0 = idle, 1 = command out, 2 = completion cycle.
  // kind 0 = IC read, 1 = DC read, 2 = DC write.
  int           m_phase;
  int           m_kind;
  int           m_starve;
  logic [31:0]  m_addr;
  logic [255:0] m_wdata;
  logic [255:0] m_ic_data;
  logic [255:0] m_dr_data;

  int   n_dgr;
  int   rd_cycles;
  logic ic_won;
  logic prev_read;

  function automatic logic [255:0] rand_blk();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s/%s observed=%h expected=%h", tcase, tag, obs, exp);
  endtask

  task automatic model_reset();
    m_phase   = 0;
    m_kind    = 0;
    m_starve  = 0;
    m_addr    = '0;
    m_wdata   = '0;
    m_ic_data = '0;
    m_dr_data = '0;
  endtask

  task automatic check_all();
    chk("mem_blk_read",  256'(mem_blk_read),  256'(m_phase == 1 && m_kind != 2));
    chk("mem_blk_write", 256'(mem_blk_write), 256'(m_phase == 1 && m_kind == 2));
    chk("mem_addr",      256'(mem_addr),      256'(m_addr));
    chk("mem_wdata",     mem_wdata,           m_wdata);
    chk("ic_done",       256'(ic_done),       256'(m_phase == 2 && m_kind == 0));
    chk("dc_rd_done",    256'(dc_rd_done),    256'(m_phase == 2 && m_kind == 1));
    chk("dc_wr_done",    256'(dc_wr_done),    256'(m_phase == 2 && m_kind == 2));
    chk("ic_data",       ic_data,             m_ic_data);
    chk("dc_rd_data",    dc_rd_data,          m_dr_data);
    chk("busy",          256'(busy),          256'(m_phase != 0));
  endtask

  // Advance the model on the inputs the DUT is about to sample, clock, then compare.
  task automatic step();
    int  k;
    logic [31:0] a;
    k = -1;
    if (m_phase == 0) begin
      if (ic_req && m_starve == STARVE_LIMIT) k = 0;
      else if (dc_wr_req) k = 2;
      else if (dc_rd_req) k = 1;
      else if (ic_req) k = 0;
      if (!ic_req || k == 0) m_starve = 0;
      else m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT;
      if (k >= 0) begin
        a = (k == 0) ? ic_addr : ((k == 1) ? dc_rd_addr : dc_wr_addr);
        m_phase = 1;
        m_kind  = k;
        m_addr  = {a[31:5], 5'd0};
        if (k == 2) m_wdata = dc_wr_data;
      end
    end else if (m_phase == 1) begin
      if ((m_kind == 2) ? mem_wr_valid : mem_rd_valid) begin
        m_phase = 2;
        if (m_kind == 0) m_ic_data = mem_rdata;
        else if (m_kind == 1) m_dr_data = mem_rdata;
      end
    end else begin
      m_phase = 0;
    end
    @(posedge CLK);
    #1;
    check_all();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET = 1'b0; ic_req = 0; dc_rd_req = 0; dc_wr_req = 0;
    ic_addr = '0; dc_rd_addr = '0; dc_wr_addr = '0; dc_wr_data = '0;
    mem_rdata = '0; mem_rd_valid = 0; mem_wr_valid = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_all();
    RESET = 1'b1;

    // Lone IC read, memory answers on the 4th command cycle; stray write valid ignored.
    tcase = "ic_lone";
    ic_req = 1; ic_addr = 32'h0040_001C;
    step();
    chk("addr_aligned", 256'(mem_addr), 256'(32'h0040_0000));
    rd_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      rd_cycles += int'(mem_blk_read);
      mem_wr_valid = (i == 1);
      if (i == 3) begin
        mem_rd_valid = 1;
        mem_rdata    = {32{8'hA5}};
      end
      step();
    end
    chk("read_hold_cycles", 256'(rd_cycles), 256'(4));
    chk("done_pulse", 256'(ic_done), 256'(1));
    chk("data_a5", ic_data, {32{8'hA5}});
    mem_rd_valid = 0; mem_wr_valid = 0; ic_req = 0;
    step();
    mem_rd_valid = 1; mem_rdata = rand_blk();
    step();
    mem_rd_valid = 0;
    step();

    // Simultaneous writeback and read: write goes first.
    tcase = "wr_then_rd";
    dc_wr_req = 1; dc_wr_addr = 32'h1000_0020; dc_wr_data = rand_blk();
    dc_rd_req = 1; dc_rd_addr = 32'h1000_0040;
    step();
    chk("first_is_write", 256'(mem_blk_write), 256'(1));
    chk("write_addr", 256'(mem_addr), 256'(32'h1000_0020));
    mem_wr_valid = 1;
    step();
    chk("wr_done", 256'(dc_wr_done), 256'(1));
    mem_wr_valid = 0; dc_wr_req = 0;
    step();
    step();
    chk("read_addr", 256'(mem_addr), 256'(32'h1000_0040));
    mem_rd_valid = 1; mem_rdata = rand_blk();
    step();
    chk("rd_done", 256'(dc_rd_done), 256'(1));
    mem_rd_valid = 0; dc_rd_req = 0;
    step();

    // IC held against back-to-back DC reads: exactly STARVE_LIMIT D grants, then IC.
    tcase = "starve";
    ic_req = 1; ic_addr = 32'h3000_0000;
    dc_rd_req = 1; dc_rd_addr = 32'h2000_0000;
    n_dgr = 0; ic_won = 0;
    for (int i = 0; i < 80 && !ic_won; i++) begin
      prev_read    = mem_blk_read;
      mem_rd_valid = mem_blk_read;
      mem_rdata    = rand_blk();
      step();
      if (mem_blk_read && !prev_read) begin
        if (mem_addr == 32'h3000_0000) ic_won = 1;
        else n_dgr++;
      end
    end
    chk("ic_granted", 256'(ic_won), 256'(1));
    chk("d_grants", 256'(n_dgr), 256'(STARVE_LIMIT));
    mem_rd_valid = 1; mem_rdata = rand_blk();
    step();
    chk("ic_done", 256'(ic_done), 256'(1));
    mem_rd_valid = 0; ic_req = 0; dc_rd_req = 0;
    step();

    // Reset two cycles into a DC read: abandoned, no done; reissue served.
    tcase = "reset_mid";
    dc_rd_req = 1; dc_rd_addr = 32'h1234_5678;
    step();
    step();
    RESET = 0;
    #1;
    model_reset();
    check_all();
    dc_rd_req = 0;
    @(posedge CLK);
    #1;
    check_all();
    RESET = 1;
    step();
    dc_rd_req = 1;
    step();
    chk("reissue_addr", 256'(mem_addr), 256'(32'h1234_5660));
    mem_rd_valid = 1; mem_rdata = rand_blk();
    step();
    chk("reissue_done", 256'(dc_rd_done), 256'(1));
    mem_rd_valid = 0; dc_rd_req = 0;
    step();

    // IC drops its request right after the grant: transaction still completes.
    tcase = "ic_drop";
    ic_req = 1; ic_addr = 32'h0000_ABCD;
    step();
    ic_req = 0;
    step();
    step();
    mem_rd_valid = 1; mem_rdata = rand_blk();
    step();
    chk("done_after_drop", 256'(ic_done), 256'(1));
    mem_rd_valid = 0;
    step();
    chk("back_to_idle", 256'(busy), 256'(0));

    // Random traffic: requesters hold until their done, memory answers (and glitches) at random.
    tcase = "random";
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (ic_req && m_phase == 2 && m_kind == 0) ic_req = 0;
      else if (!ic_req && $urandom_range(2) == 0) begin
        ic_req = 1; ic_addr = $urandom();
      end
      if (dc_rd_req && m_phase == 2 && m_kind == 1) dc_rd_req = 0;
      else if (!dc_rd_req && $urandom_range(2) == 0) begin
        dc_rd_req = 1; dc_rd_addr = $urandom();
      end
      if (dc_wr_req && m_phase == 2 && m_kind == 2) dc_wr_req = 0;
      else if (!dc_wr_req && $urandom_range(3) == 0) begin
        dc_wr_req = 1; dc_wr_addr = $urandom(); dc_wr_data = rand_blk();
      end
      mem_rd_valid = ($urandom_range(3) == 0);
      mem_wr_valid = ($urandom_range(3) == 0);
      mem_rdata    = rand_blk();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one block-wide main-memory port between the I-cache refill path and the D-cache refill/writeback paths.
- Sits between the IC/DC controllers and the memory block interface: block_read/block_write, address, valid strobes.
- Serialises transactions, one outstanding at a time.
- Fixed priority with an anti-starvation override for instruction fetch.

Parameters:
- ADDR_W, 32, byte address width.
- BLK_W, 256, cache block width in bits (32-byte block).
- STARVE_LIMIT, 4, consecutive D-side grants allowed while ic_req is pending before IC is forced to win.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- ic_req  in  1  I-cache block read request; held until ic_done.
- ic_addr  in  ADDR_W  I-cache miss address.
- ic_data  out  BLK_W  block returned to I-cache.
- ic_done  out  1  one-cycle pulse; ic_data valid this cycle.
- dc_rd_req  in  1  D-cache block read request.
- dc_rd_addr  in  ADDR_W  D-cache miss address.
- dc_rd_data  out  BLK_W  block returned to D-cache.
- dc_rd_done  out  1  one-cycle pulse.
- dc_wr_req  in  1  D-cache dirty writeback request.
- dc_wr_addr  in  ADDR_W  writeback address.
- dc_wr_data  in  BLK_W  writeback block.
- dc_wr_done  out  1  one-cycle pulse; write accepted by memory.
- mem_addr  out  ADDR_W  block-aligned address to memory.
- mem_blk_read  out  1  block read command.
- mem_blk_write  out  1  block write command.
- mem_wdata  out  BLK_W  block write data.
- mem_rdata  in  BLK_W  block read data.
- mem_rd_valid  in  1  read completed; mem_rdata valid.
- mem_wr_valid  in  1  write completed.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered.
- RESET low (asynchronous): state=IDLE, starve count=0; every output=0, including data buses.
- States:
  - IDLE: evaluate requests every cycle.
  - I_RD, D_RD, D_WR: memory command held.
  - DONE: one cycle; requests are ignored so the requester can drop its req.
- IDLE arbitration, first match wins:
  - (a) ic_req and starve count==STARVE_LIMIT -> I_RD.
  - (b) dc_wr_req -> D_WR.
  - (c) dc_rd_req -> D_RD.
  - (d) ic_req -> I_RD.
- Writeback beats D-side read so that the eviction precedes the refill.
- On grant, latch the selected address with bits [4:0] forced to 0, and latch dc_wr_data for D_WR.
  - mem_addr and mem_blk_read / mem_blk_write / mem_wdata assert in the next cycle.
- Command hold: the command stays asserted, with address and data stable, until the matching valid is sampled high.
  - D_WR completes on mem_wr_valid only.
  - I_RD and D_RD complete on mem_rd_valid only.
  - A non-matching valid, or any valid in IDLE or DONE, is ignored.
- Completion cycle: deassert the command, capture mem_rdata into ic_data or dc_rd_data, go to DONE.
  - The matching done pulses high for exactly the DONE cycle, then the FSM returns to IDLE.
  - ic_data and dc_rd_data hold their value until their next completion.
- Latency:
  - req sampled in IDLE at cycle N -> command visible at N+1.
  - valid at cycle M -> done high at M+1.
  - Earliest re-arbitration is at M+2.
  - Memory returning valid in the same cycle the command first appears gives the minimum 3-cycle turnaround.
- Starve counter:
  - Increments on each D-side grant made while ic_req is high.
  - Resets to 0 on an IC grant, or when ic_req is low in IDLE.
  - Saturates at STARVE_LIMIT.
- A requester dropping its req mid-transaction does not abort: the transaction completes and done still pulses.
- Simultaneous dc_wr_req and dc_rd_req: write served first; the read is granted at the next IDLE unless starvation forces IC.
- RESET asserted mid-transaction: the transaction is abandoned and no done pulse occurs; requesters must reissue after reset.

Decomposition:
- Shared package holds:
  - state enum {IDLE, I_RD, D_RD, D_WR, DONE};
  - BLK_OFFSET_BITS=5;
  - the block-align helper constant.
- One natural sub-module: mem_port_prio_sel, the combinational priority and starvation selector producing a one-hot grant.
- The FSM and datapath registers stay in the top.

Test Plan:
- Lone ic_req with ic_addr=0x0040_001C, mem_rd_valid 4 cycles after command with data 0xA5..A5 -> mem_addr=0x0040_0000, mem_blk_read held 4 cycles, ic_done one pulse with ic_data=0xA5..A5.
- dc_wr_req (addr 0x1000_0020) and dc_rd_req (addr 0x1000_0040) in the same cycle -> D_WR first, mem_blk_write with dc_wr_data; then D_RD at 0x1000_0040; dc_wr_done precedes dc_rd_done.
- ic_req held while DC issues back-to-back reads with STARVE_LIMIT=4 -> exactly 4 D_RD grants, then an I_RD grant even though dc_rd_req is still high.
- mem_wr_valid pulsed during I_RD, and mem_rd_valid pulsed in IDLE -> both ignored; I_RD waits for mem_rd_valid; no spurious done.
- RESET low two cycles into D_RD -> all outputs 0 asynchronously, no dc_rd_done; after release, re-asserted dc_rd_req is served normally.
- Requester drops ic_req one cycle after grant -> I_RD still completes, ic_done pulses once, FSM returns to IDLE.
